pipelined_instruction_decoder: RTL and testbench

Registered decode stage between the IF/ID and ID/EX pipeline registers. It extracts the instruction fields and generates the sign-extended immediate for all RV32I formats. It classifies the format and flags illegal encodings. A valid/ready handshake with a 2-entry skid buffer sits on the output, so back-pressure from EX never combinationally reaches fetch. The output also supports flush for branch redirect.

---
 rtl/decode_pkg.sv | 61 ++++++
 rtl/pipelined_instruction_decoder_imm_gen.sv | 83 ++++++++
 rtl/pipelined_instruction_decoder.sv | 131 +++++++++++++
 tb/tb_pipelined_instruction_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I/RV64I decode stage: opcodes, format
// enumeration and the decoded bundle carried through the output buffer.
package decode_pkg;

    // Widest datapath / PC the bundle must hold; instances use the low bits.
    localparam int MAX_XLEN = 64;
    localparam int MAX_PC_W = 64;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // FMT_NONE is encoded as zero so a cleared bundle reads as "no format".
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [2:0]          func3;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [6:0]          func7;
        logic [MAX_XLEN-1:0] imm;
        fmt_e                fmt;
        logic                illegal;
        logic [MAX_PC_W-1:0] pc;
    } decoded_t;

    // Instruction format implied by the major opcode alone.
    function automatic fmt_e opc_to_fmt(input logic [6:0] opc);
        fmt_e f;
        case (opc)
            OPC_LUI, OPC_AUIPC:                     f = FMT_U;
            OPC_JAL:                                f = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_MISC_MEM, OPC_SYSTEM:               f = FMT_I;
            OPC_STORE:                              f = FMT_S;
            OPC_BRANCH:                             f = FMT_B;
            OPC_OP:                                 f = FMT_R;
            default:                                f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/pipelined_instruction_decoder_imm_gen.sv
// Combinational decode: format classification, legality check and the
// sign-extended immediate. Illegal encodings yield imm=0 and FMT_NONE.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit EN_M_EXT = 1'b0
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output fmt_e            o_fmt,
    output logic            o_illegal
);

    logic [6:0]         w_opc;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    fmt_e               w_fmt_raw;
    logic               w_illegal;
    logic signed [31:0] w_imm32;
    logic signed [XLEN-1:0] w_imm_ext;

    assign w_opc     = i_instr[6:0];
    assign w_f3      = i_instr[14:12];
    assign w_f7      = i_instr[31:25];
    assign w_fmt_raw = opc_to_fmt(w_opc);

    // Legality: reject non-32-bit encodings, unknown opcodes and reserved func fields.
    always_comb begin
        w_illegal = 1'b0;
        if (i_instr[1:0] != 2'b11 || w_fmt_raw == FMT_NONE)
            w_illegal = 1'b1;
        case (w_opc)
            OPC_JALR:
                if (w_f3 != 3'b000) w_illegal = 1'b1;
            OPC_BRANCH:
                if (w_f3 == 3'b010 || w_f3 == 3'b011) w_illegal = 1'b1;
            OPC_LOAD: begin
                if (w_f3 == 3'b111) w_illegal = 1'b1;
                if (XLEN == 32 && (w_f3 == 3'b011 || w_f3 == 3'b110)) w_illegal = 1'b1;
            end
            OPC_STORE: begin
                if (w_f3[2]) w_illegal = 1'b1;
                if (XLEN == 32 && w_f3 == 3'b011) w_illegal = 1'b1;
            end
            OPC_OP: begin
                if (!((w_f7 == 7'b0000000) ||
                      (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) ||
                      (w_f7 == 7'b0000001 && EN_M_EXT)))
                    w_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                if (w_f3 == 3'b001 && w_f7 != 7'b0000000) w_illegal = 1'b1;
                if (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000)
                    w_illegal = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate assembly per format, sign-carrying in a 32-bit signed value.
    always_comb begin
        w_imm32 = '0;
        case (w_fmt_raw)
            FMT_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U: w_imm32 = {i_instr[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Size cast of a signed value sign-extends to the datapath width.
    assign w_imm_ext = XLEN'(w_imm32);

    assign o_illegal = w_illegal;
    assign o_fmt     = w_illegal ? FMT_NONE : w_fmt_raw;
    assign o_imm     = w_illegal ? '0 : w_imm_ext;

endmodule

// File: rtl/pipelined_instruction_decoder.sv
// Registered decode stage with a 2-entry (main + skid) output buffer.
// in_ready is a register (!skid valid), so EX back-pressure never reaches
// fetch combinationally.
module pipelined_instruction_decoder
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PC_W     = 32,
    parameter bit EN_M_EXT = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_func3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_func7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_pc
);

    logic [XLEN-1:0] w_imm;
    fmt_e            w_fmt;
    logic            w_illegal;
    decoded_t        w_new;
    logic            w_accept;
    logic            w_emit;
    logic            w_s_vld_nxt;
    logic            w_unused;

    decoded_t        r_m;
    decoded_t        r_s;
    logic            r_m_vld;
    logic            r_s_vld;
    logic            r_in_ready;

    imm_gen #(
        .XLEN     (XLEN),
        .EN_M_EXT (EN_M_EXT)
    ) u_imm_gen (
        .i_instr   (in_instr),
        .o_imm     (w_imm),
        .o_fmt     (w_fmt),
        .o_illegal (w_illegal)
    );

    // Pack the freshly decoded instruction into a bundle.
    always_comb begin
        w_new         = '0;
        w_new.opcode  = in_instr[6:0];
        w_new.rd      = in_instr[11:7];
        w_new.func3   = in_instr[14:12];
        w_new.rs1     = in_instr[19:15];
        w_new.rs2     = in_instr[24:20];
        w_new.func7   = in_instr[31:25];
        w_new.imm     = MAX_XLEN'(w_imm);
        w_new.fmt     = w_fmt;
        w_new.illegal = w_illegal;
        w_new.pc      = MAX_PC_W'(in_pc);
    end

    assign w_accept = in_valid & r_in_ready;
    assign w_emit   = r_m_vld & out_ready;

    // Skid fills only when M is held; it drains whenever M is emitted.
    assign w_s_vld_nxt = (w_emit && r_s_vld)               ? 1'b0 :
                         (r_m_vld && !w_emit && w_accept)  ? 1'b1 : r_s_vld;

    // Main/skid buffer update: reset clears everything, flush invalidates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m        <= '0;
            r_s        <= '0;
            r_m_vld    <= 1'b0;
            r_s_vld    <= 1'b0;
            r_in_ready <= 1'b0;
        end else if (flush) begin
            r_m_vld    <= 1'b0;
            r_s_vld    <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_emit) begin
                if (r_s_vld) begin
                    r_m     <= r_s;
                    r_m_vld <= 1'b1;
                end else if (w_accept) begin
                    r_m     <= w_new;
                    r_m_vld <= 1'b1;
                end else begin
                    r_m_vld <= 1'b0;
                end
            end else if (!r_m_vld) begin
                if (w_accept) begin
                    r_m     <= w_new;
                    r_m_vld <= 1'b1;
                end
            end else if (w_accept) begin
                r_s <= w_new;
            end
            r_s_vld    <= w_s_vld_nxt;
            r_in_ready <= !w_s_vld_nxt;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_m_vld;
    assign out_opcode  = r_m.opcode;
    assign out_rd      = r_m.rd;
    assign out_func3   = r_m.func3;
    assign out_rs1     = r_m.rs1;
    assign out_rs2     = r_m.rs2;
    assign out_func7   = r_m.func7;
    assign out_imm     = r_m.imm[XLEN-1:0];
    assign out_fmt     = r_m.fmt;
    assign out_illegal = r_m.illegal;
    assign out_pc      = r_m.pc[PC_W-1:0];

    // Upper bits of the max-width bundle fields are intentionally dropped.
    assign w_unused = ^{r_m.imm, r_m.pc};

endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// Directed bench for pipelined_instruction_decoder: reset, decode of each
// format, back-pressure through the skid buffer, flush, illegal encodings
// (with and without the M extension) and mid-stream reset.
module tb_pipelined_instruction_decoder;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready, out_valid, out_illegal;
    logic [6:0]  out_opcode, out_func7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_func3, out_fmt;
    logic [31:0] out_imm, out_pc;

    logic        m_in_ready, m_out_valid, m_out_illegal;
    logic [6:0]  m_out_opcode, m_out_func7;
    logic [4:0]  m_out_rd, m_out_rs1, m_out_rs2;
    logic [2:0]  m_out_func3, m_out_fmt;
    logic [31:0] m_out_imm, m_out_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipelined_instruction_decoder #(.XLEN(32), .PC_W(32), .EN_M_EXT(1'b0)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_func3(out_func3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_func7(out_func7),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_pc(out_pc)
    );

    pipelined_instruction_decoder #(.XLEN(32), .PC_W(32), .EN_M_EXT(1'b1)) dut_m (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(m_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(m_out_valid), .out_ready(out_ready),
        .out_opcode(m_out_opcode), .out_rd(m_out_rd), .out_func3(m_out_func3),
        .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_func7(m_out_func7),
        .out_imm(m_out_imm), .out_fmt(m_out_fmt), .out_illegal(m_out_illegal), .out_pc(m_out_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic chk_bundle(input string tag, input logic [2:0] fmt,
                              input logic [31:0] imm, input logic ill, input logic [31:0] pc);
        chk({tag, ".valid"},   64'(out_valid),   64'(1'b1));
        chk({tag, ".fmt"},     64'(out_fmt),     64'(fmt));
        chk({tag, ".imm"},     64'(out_imm),     64'(imm));
        chk({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
        chk({tag, ".pc"},      64'(out_pc),      64'(pc));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        // Reset state
        tick(); tick();
        chk("rst.in_ready",  64'(in_ready),  64'(1'b0));
        chk("rst.out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst.fmt",       64'(out_fmt),   64'(FMT_NONE));
        chk("rst.imm",       64'(out_imm),   64'(0));
        chk("rst.pc",        64'(out_pc),    64'(0));
        reset = 1'b0;
        tick();
        chk("post_rst.in_ready",  64'(in_ready),  64'(1'b1));
        chk("post_rst.out_valid", 64'(out_valid), 64'(1'b0));

        // addi x1,x2,-5
        out_ready = 1'b1;
        drive(1'b1, 32'hFFB10093, 32'h100);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk_bundle("addi", FMT_I, 32'hFFFFFFFB, 1'b0, 32'h100);
        chk("addi.rd",    64'(out_rd),    64'(1));
        chk("addi.rs1",   64'(out_rs1),   64'(2));
        chk("addi.func3", 64'(out_func3), 64'(0));
        tick();
        chk("addi.drain", 64'(out_valid), 64'(1'b0));

        // Back-to-back S/B/J/U, one per cycle
        drive(1'b1, 32'h00512423, 32'h110);
        tick();
        chk_bundle("sw", FMT_S, 32'h00000008, 1'b0, 32'h110);
        chk("sw.rs2", 64'(out_rs2), 64'(5));
        drive(1'b1, 32'hFE000EE3, 32'h114);
        tick();
        chk_bundle("beq", FMT_B, 32'hFFFFFFFC, 1'b0, 32'h114);
        drive(1'b1, 32'h001000EF, 32'h118);
        tick();
        chk_bundle("jal", FMT_J, 32'h00000800, 1'b0, 32'h118);
        drive(1'b1, 32'h123451B7, 32'h11C);
        tick();
        chk_bundle("lui", FMT_U, 32'h12345000, 1'b0, 32'h11C);
        chk("lui.rd", 64'(out_rd), 64'(3));
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("b2b.drain", 64'(out_valid), 64'(1'b0));

        // Back-pressure: out_ready low for 4 edges while feeding A, B, C
        out_ready = 1'b0;
        drive(1'b1, 32'hFFB10093, 32'h200);
        tick();
        chk("bp1.in_ready", 64'(in_ready), 64'(1'b1));
        chk("bp1.pc",       64'(out_pc),   64'(32'h200));
        drive(1'b1, 32'h00512423, 32'h204);
        tick();
        chk("bp2.in_ready", 64'(in_ready), 64'(1'b0));
        chk("bp2.pc",       64'(out_pc),   64'(32'h200));
        drive(1'b1, 32'hFE000EE3, 32'h208);
        tick();
        chk("bp3.in_ready", 64'(in_ready), 64'(1'b0));
        chk_bundle("bp3.hold", FMT_I, 32'hFFFFFFFB, 1'b0, 32'h200);
        tick();
        chk("bp4.in_ready", 64'(in_ready), 64'(1'b0));
        chk("bp4.pc",       64'(out_pc),   64'(32'h200));
        out_ready = 1'b1;
        tick();
        chk_bundle("bp.B", FMT_S, 32'h00000008, 1'b0, 32'h204);
        chk("bp.B.in_ready", 64'(in_ready), 64'(1'b1));
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk_bundle("bp.C", FMT_B, 32'hFFFFFFFC, 1'b0, 32'h208);
        tick();
        chk("bp.drain", 64'(out_valid), 64'(1'b0));

        // Flush with M and S full and an instruction presented
        out_ready = 1'b0;
        drive(1'b1, 32'hFFB10093, 32'h300);
        tick();
        drive(1'b1, 32'h00512423, 32'h304);
        tick();
        chk("fl.full.in_ready", 64'(in_ready), 64'(1'b0));
        drive(1'b1, 32'h001000EF, 32'h308);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl.out_valid", 64'(out_valid), 64'(1'b0));
        chk("fl.in_ready",  64'(in_ready),  64'(1'b1));
        out_ready = 1'b1;
        tick();
        chk("fl.after1", 64'(out_valid), 64'(1'b0));
        tick();
        chk("fl.after2", 64'(out_valid), 64'(1'b0));

        // Flush while empty drops a same-cycle accept
        drive(1'b1, 32'h123451B7, 32'h30C);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl2.out_valid", 64'(out_valid), 64'(1'b0));
        tick();
        chk("fl2.after", 64'(out_valid), 64'(1'b0));

        // Illegal encodings
        drive(1'b1, 32'h00000000, 32'h400);
        tick();
        chk_bundle("zero", FMT_NONE, 32'h0, 1'b1, 32'h400);
        drive(1'b1, 32'h023100B3, 32'h404);
        tick();
        chk_bundle("mul.noM", FMT_NONE, 32'h0, 1'b1, 32'h404);
        chk("mul.noM.rd",    64'(out_rd),    64'(1));
        chk("mul.noM.func7", 64'(out_func7), 64'(7'b0000001));
        chk("mul.M.valid",   64'(m_out_valid),   64'(1'b1));
        chk("mul.M.illegal", 64'(m_out_illegal), 64'(1'b0));
        chk("mul.M.fmt",     64'(m_out_fmt),     64'(FMT_R));
        chk("mul.M.imm",     64'(m_out_imm),     64'(0));
        drive(1'b1, 32'h00002063, 32'h408);
        tick();
        chk_bundle("br.f3_010", FMT_NONE, 32'h0, 1'b1, 32'h408);
        drive(1'b1, 32'h40115093, 32'h40C);
        tick();
        chk_bundle("srai", FMT_I, 32'h00000401, 1'b0, 32'h40C);
        drive(1'b1, 32'h00113023, 32'h410);
        tick();
        chk_bundle("sd.rv32", FMT_NONE, 32'h0, 1'b1, 32'h410);
        drive(1'b0, 32'h0, 32'h0);
        tick();

        // Reset mid-stream with M and S full
        out_ready = 1'b0;
        drive(1'b1, 32'hFFB10093, 32'h500);
        tick();
        drive(1'b1, 32'h00512423, 32'h504);
        tick();
        chk("mrst.full.in_ready", 64'(in_ready), 64'(1'b0));
        reset = 1'b1;
        tick();
        chk("mrst.in_ready",  64'(in_ready),  64'(1'b0));
        chk("mrst.out_valid", 64'(out_valid), 64'(1'b0));
        chk("mrst.rd",        64'(out_rd),    64'(0));
        chk("mrst.imm",       64'(out_imm),   64'(0));
        chk("mrst.fmt",       64'(out_fmt),   64'(FMT_NONE));
        chk("mrst.pc",        64'(out_pc),    64'(0));
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("mrst.after.in_ready",  64'(in_ready),   64'(1'b1));
        chk("mrst.after.out_valid", 64'(out_valid),  64'(1'b0));
        chk("mrst.after.opcode",    64'(out_opcode), 64'(0));
        chk("mrst.after.func7",     64'(out_func7),  64'(0));
        out_ready = 1'b1;
        tick();
        chk("mrst.after2.out_valid", 64'(out_valid), 64'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
